// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-side signal bundle for the instruction cache
interface icache_if;
    logic        dp_imemREN;
    logic [31:0] dp_imemaddr;
    logic        dp_flush;
    logic        dp_ihit;
    logic [31:0] dp_imemload;
    logic        ram_iREN;
    logic [31:0] ram_iaddr;
    logic        ram_iwait;
    logic [31:0] ram_iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport master (
        output dp_imemREN, dp_imemaddr, dp_flush, ram_iwait, ram_iload,
        input  dp_ihit, dp_imemload, ram_iREN, ram_iaddr, hit_count, miss_count
    );

    modport slave (
        input  dp_imemREN, dp_imemaddr, dp_flush, ram_iwait, ram_iload,
        output dp_ihit, dp_imemload, ram_iREN, ram_iaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-block instruction cache
// Hit/miss counters are built only when ICACHE_STATS_EN is defined.
module icache #(
    parameter int SETS = 16
) (
    input logic     CLK,
    input logic     RST,
    icache_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag [SETS];
    logic [31:0]       r_data [SETS];
    logic [29:0]       r_mword;

    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_midx;
    logic [TAG_W-1:0]  w_tag;
    logic [TAG_W-1:0]  w_mtag;
    logic              w_lookup;
    logic              w_hit;
    logic              w_miss_start;
    logic              w_fill;
    logic              w_unused;

    assign w_idx    = bus.dp_imemaddr[IDX_W+1:2];
    assign w_tag    = bus.dp_imemaddr[31:IDX_W+2];
    assign w_midx   = r_mword[IDX_W-1:0];
    assign w_mtag   = r_mword[29:IDX_W];
    assign w_unused = ^bus.dp_imemaddr[1:0];

    // Flush suppresses both the hit and the start of a new miss in the same cycle.
    assign w_lookup     = bus.dp_imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_hit        = (r_state == IDLE) & w_lookup & ~bus.dp_flush;
    assign w_miss_start = (r_state == IDLE) & bus.dp_imemREN & ~w_lookup & ~bus.dp_flush;
    assign w_fill       = (r_state == FETCH) & ~bus.ram_iwait & ~bus.dp_flush;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_miss_start) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                if (bus.dp_flush || !bus.ram_iwait) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.dp_ihit     = 1'b0;
        bus.dp_imemload = 32'h0;
        bus.ram_iREN    = 1'b0;
        bus.ram_iaddr   = 32'h0;
        if (r_state == FETCH) begin
            bus.ram_iREN  = 1'b1;
            bus.ram_iaddr = {r_mword, 2'b00};
        end else if (w_hit) begin
            bus.dp_ihit     = 1'b1;
            bus.dp_imemload = r_data[w_idx];
        end
    end

    // The fill always lands on the latched miss address, even if the fetch address moved.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= '0;
            r_mword <= '0;
            for (int i = 0; i < SETS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (bus.dp_flush) begin
                r_valid <= '0;
            end else if (w_fill) begin
                r_valid[w_midx] <= 1'b1;
                r_tag[w_midx]   <= w_mtag;
                r_data[w_midx]  <= bus.ram_iload;
            end
            if (w_miss_start) begin
                r_mword <= bus.dp_imemaddr[31:2];
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit && (r_hit_count != 32'hFFFFFFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss_start && (r_miss_count != 32'hFFFFFFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;
`else
    assign bus.hit_count  = 32'h0;
    assign bus.miss_count = 32'h0;
`endif
endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-block instruction cache that answers the datapath's instruction fetch requests (imemREN/imemaddr → ihit/imemload). It sits between the pipeline's IF stage and the memory controller's instruction port. On a miss it issues a single-word read (iREN/iaddr, stalled by iwait) and fills the line. The pipeline stalls on ihit=0.

## Interface
- SETS, 16, number of sets; power of two, ≥2; IDX_W = log2(SETS), TAG_W = 30 − IDX_W
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- dp_imemREN  input  1  datapath fetch request
- dp_imemaddr  input  32  fetch byte address; bits [1:0] ignored
- dp_flush  input  1  invalidate all lines
- dp_ihit  output  1  imemload valid this cycle
- dp_imemload  output  32  instruction word
- ram_iREN  output  1  memory read request
- ram_iaddr  output  32  memory word address, bits [1:0] = 0
- ram_iwait  input  1  memory not ready; data valid when low while iREN high
- ram_iload  input  32  memory read data
- hit_count  output  32  hit counter (see Configuration)
- miss_count  output  32  miss counter (see Configuration)

## Operation
- Address split: index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2].
- Per set: valid bit, TAG_W tag, 32-bit data word.
- States: IDLE, FETCH.
- IDLE: hit = dp_imemREN & valid[index] & (tag match). dp_ihit = hit (combinational); dp_imemload = hit ? data[index] : 0.
- IDLE, dp_imemREN=1, no hit, dp_flush=0: latch miss address {addr[31:2],2'b00} into maddr; → FETCH.
- IDLE, dp_imemREN=0: no hit, no fetch, stay IDLE.
- FETCH: dp_ihit=0, dp_imemload=0; ram_iREN=1, ram_iaddr=maddr (stable for whole state).
- FETCH, ram_iwait=0: write data=ram_iload, tag, valid=1 at maddr index; → IDLE.
- FETCH, ram_iwait=1: hold.
- Address change while in FETCH: fill still targets maddr; new address is looked up on return to IDLE.
- Outside FETCH: ram_iREN=0, ram_iaddr=0.
- dp_flush=1: all valid bits cleared at the edge; dp_ihit forced 0 that cycle; in FETCH, any same-cycle fill is dropped and state → IDLE; in IDLE no miss is started.
- Fill overwrites the set unconditionally (conflict eviction).

## Timing
- Reset: state IDLE, all valid=0, all data/tag=0, maddr=0; dp_ihit=0, dp_imemload=0, ram_iREN=0, ram_iaddr=0, counters=0.
- Hit: zero latency, dp_ihit in the same cycle as request.
- Miss, zero-wait memory: cycle 0 miss detected; cycle 1 FETCH with iwait=0, fill at end; cycle 2 dp_ihit=1. Each iwait=1 cycle adds one.
- RST mid-FETCH: abort, no fill, reset values next cycle.
- No outputs registered other than via state; dp_ihit/imemload combinational from state and arrays.

## Configuration
- ICACHE_STATS_EN defined: hit_count +1 each cycle dp_ihit=1; miss_count +1 on each IDLE→FETCH transition; both saturate at 32'hFFFFFFFF; cleared only by RST (not by flush).
- Not defined: counters not built; hit_count=miss_count=0 always.

## Test plan
- Reset then dp_imemREN=1, addr 0x00000000 → dp_ihit=0 cycle 0; cycle 1 ram_iREN=1, ram_iaddr=0x00000000.
- Cold miss addr 0x00000040, iwait=0, ram_iload=0x3C010001 → dp_ihit=1, dp_imemload=0x3C010001 in cycle 2; repeated fetch hits with ram_iREN=0.
- Wait states: iwait=1 for 3 cycles then 0 → ram_iREN held 4 cycles, ram_iaddr stable, dp_ihit=0 throughout, hit 1 cycle after iwait falls.
- Conflict: fill 0x00000004 then 0x00000044 (both index 1, SETS=16) → second misses and evicts; refetch 0x00000004 misses again.
- Flush during FETCH with iwait=0 same cycle → no fill, all valid cleared, state IDLE; previously cached address misses.
- With ICACHE_STATS_EN: 2 misses then 3 hit cycles → miss_count=2, hit_count=3; without macro both read 0.
